pwm_fade_ctrl: RTL and testbench



---
 rtl/pwm_fade_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - PWM duty ramp sequencer that updates duty only on period boundaries.
// Optional breathe mode (continuous up/down ramping) is enabled by defining PWM_FADE_BREATHE_EN.
module pwm_fade_ctrl #(
    parameter int BITS      = 8,
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [BITS-1:0]      cfg_target,
    input  logic [BITS-1:0]      cfg_step,
    input  logic [RATE_BITS-1:0] cfg_rate,
`ifdef PWM_FADE_BREATHE_EN
    input  logic                 cfg_loop,
`endif
    input  logic                 abort,
    output logic [BITS-1:0]      duty,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BITS-1:0]      r_pcnt;
    logic [RATE_BITS-1:0] r_rcnt;
    logic [RATE_BITS-1:0] r_rate;
    logic [BITS-1:0]      r_duty;
    logic [BITS-1:0]      r_target;
    logic [BITS-1:0]      r_step;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_step_evt;
    logic                 w_up;
    logic [BITS-1:0]      w_diff;
    logic [BITS-1:0]      w_stepped;
    logic                 w_hit;
    logic                 w_loop;
    logic [BITS-1:0]      w_cfg_step;

`ifdef PWM_FADE_BREATHE_EN
    logic                 r_loop;
    logic [BITS-1:0]      r_origin;
    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    assign wrap       = (r_pcnt == {BITS{1'b1}});
    assign cfg_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_RAMP);
    assign done       = r_done;
    assign duty       = r_duty;
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_cfg_step = (cfg_step == '0) ? {{(BITS-1){1'b0}}, 1'b1} : cfg_step;

    // Saturating step toward target: clamp when remaining distance fits in one step.
    always_comb begin
        w_up       = 1'b0;
        w_diff     = '0;
        w_stepped  = r_duty;
        w_step_evt = (r_state == S_RAMP) && !abort && wrap && (r_rcnt == r_rate);
        w_up       = (r_target > r_duty);
        w_diff     = w_up ? (r_target - r_duty) : (r_duty - r_target);
        if (w_diff <= r_step)
            w_stepped = r_target;
        else if (w_up)
            w_stepped = r_duty + r_step;
        else
            w_stepped = r_duty - r_step;
        w_hit = w_step_evt && (w_stepped == r_target);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (cfg_target != r_duty)) w_state_nxt = S_RAMP;
            S_RAMP: begin
                if (abort)
                    w_state_nxt = S_IDLE;
                else if (w_hit && !w_loop)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_rcnt   <= '0;
            r_rate   <= '0;
            r_duty   <= '0;
            r_target <= '0;
            r_step   <= '0;
            r_done   <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            r_loop   <= 1'b0;
            r_origin <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= r_pcnt + 1'b1;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_target <= cfg_target;
                r_step   <= w_cfg_step;
                r_rate   <= cfg_rate;
                r_rcnt   <= '0;
`ifdef PWM_FADE_BREATHE_EN
                r_loop   <= cfg_loop;
                r_origin <= r_duty;
`endif
                if (cfg_target == r_duty)
                    r_done <= 1'b1;
            end else if ((r_state == S_RAMP) && !abort && wrap) begin
                if (r_rcnt == r_rate) begin
                    r_rcnt <= '0;
                    r_duty <= w_stepped;
                    if (w_hit) begin
`ifdef PWM_FADE_BREATHE_EN
                        if (r_loop) begin
                            r_target <= r_origin;
                            r_origin <= r_target;
                        end else begin
                            r_done <= 1'b1;
                        end
`else
                        r_done <= 1'b1;
`endif
                    end
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - directed self-checking bench for pwm_fade_ctrl.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_target = '0;
    logic [7:0] cfg_step = '0;
    logic [7:0] cfg_rate = '0;
    logic       cfg_loop = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] duty;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(.BITS(8), .RATE_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_step   (cfg_step),
        .cfg_rate   (cfg_rate),
`ifdef PWM_FADE_BREATHE_EN
        .cfg_loop   (cfg_loop),
`endif
        .abort      (abort),
        .duty       (duty),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Leaves the bench on the negedge right after the next wrap edge.
    task automatic wait_wrap();
        int n = 0;
        while (!wrap && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!wrap) check("wrap_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [7:0] r, input logic lp);
        cfg_target = t;
        cfg_step   = s;
        cfg_rate   = r;
        cfg_loop   = lp;
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    logic [7:0] exp_seq [4];

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and period boundaries
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        for (int i = 0; i < 768; i++) begin
            if (i == 254) check("wrap_254", wrap, 0);
            if (i == 255 || i == 511 || i == 767) check("wrap_period", wrap, 1);
            @(negedge clk);
        end

        // Ramp up 0 -> 10 by 4
        send(8'd10, 8'd4, 8'd0, 1'b0);
        check("up_busy", busy, 1);
        check("up_ready", cfg_ready, 0);
        exp_seq = '{8'd4, 8'd8, 8'd10, 8'd0};
        for (int k = 0; k < 3; k++) begin
            wait_wrap();
            check("up_duty", duty, exp_seq[k]);
            check("up_done", done, (k == 2) ? 1 : 0);
        end
        check("up_end_busy", busy, 0);
        check("up_end_ready", cfg_ready, 1);
        @(negedge clk);
        check("up_done_single", done, 0);

        // Ramp down 10 -> 0 by 3
        send(8'd0, 8'd3, 8'd0, 1'b0);
        exp_seq = '{8'd7, 8'd4, 8'd1, 8'd0};
        for (int k = 0; k < 4; k++) begin
            wait_wrap();
            check("dn_duty", duty, exp_seq[k]);
        end
        check("dn_done", done, 1);

        // Rate divider: 0 -> 3 step 1 every 3 periods
        send(8'd3, 8'd1, 8'd2, 1'b0);
        for (int w = 1; w <= 9; w++) begin
            wait_wrap();
            check("rate_duty", duty, w / 3);
        end
        check("rate_done", done, 1);

        // 3 -> 2, then step 0 acts as 1: 2 -> 1 -> 0
        send(8'd2, 8'd1, 8'd0, 1'b0);
        wait_wrap();
        check("pre_duty", duty, 2);
        send(8'd0, 8'd0, 8'd0, 1'b0);
        wait_wrap();
        check("step0_duty1", duty, 1);
        wait_wrap();
        check("step0_duty0", duty, 0);
        check("step0_done", done, 1);

        // Single large step saturates at target, then target == duty
        send(8'd5, 8'd200, 8'd0, 1'b0);
        wait_wrap();
        check("sat_duty", duty, 5);
        @(negedge clk);
        send(8'd5, 8'd1, 8'd0, 1'b0);
        check("same_busy", busy, 0);
        check("same_done", done, 1);
        @(negedge clk);
        check("same_done_single", done, 0);

        // Ignored command mid-ramp, then abort coincident with wrap
        send(8'd0, 8'd1, 8'd0, 1'b0);
        @(negedge clk);
        check("mid_ready", cfg_ready, 0);
        send(8'd200, 8'd50, 8'd0, 1'b0);
        wait_wrap();
        check("ign_duty", duty, 4);
        while (!wrap) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_duty", duty, 4);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", cfg_ready, 1);
        @(negedge clk);
        check("abort_done2", done, 0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        send(8'd14, 8'd10, 8'd0, 1'b0);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1);
        wait_wrap();
        check("rst_mid_duty", duty, 14);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_duty0", duty, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cfg_ready, 1);

`ifdef PWM_FADE_BREATHE_EN
        send(8'd2, 8'd1, 8'd0, 1'b1);
        exp_seq = '{8'd1, 8'd2, 8'd1, 8'd0};
        for (int k = 0; k < 5; k++) begin
            wait_wrap();
            check("br_duty", duty, (k == 4) ? 8'd1 : exp_seq[k]);
            check("br_done", done, 0);
            check("br_busy", busy, 1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("br_abort_busy", busy, 0);
        check("br_abort_duty", duty, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
